qlab5_pio_seq: RTL and testbench

Blink/pulse sequencer for the qlab5 single-bit PIO. It acts as an Avalon-MM write master on the PIO slave and drives programmed on/off pulse trains through the PIO set (addr 4) and clear (addr 5) registers. A host master (Nios data port) shares the same slave through a built-in two-way arbiter. The block sits between the system interconnect and the PIO instance inside qlab5_sys.

---
 rtl/qlab5_pio_seq_pkg.sv | 25 ++
 rtl/qlab5_pio_seq_timer.sv | 43 ++++
 rtl/qlab5_pio_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_qlab5_pio_seq.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qlab5_pio_seq_pkg.sv
// qlab5_pio_seq_pkg
//   Shared types and constants for the qlab5 PIO blink/pulse sequencer.
//   - seq_state_t   : sequencer FSM states (ABORT_WR exists only when
//                     QLAB5_PIO_SEQ_ABORT_EN is defined)
//   - PIO_ADDR_*    : register offsets of the single-bit PIO slave
//   - PIO_BIT       : bit mask of the one output bit
package qlab5_pio_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_WR,
    ST_ON_CNT,
    ST_CLR_WR,
    ST_OFF_CNT
`ifdef QLAB5_PIO_SEQ_ABORT_EN
    , ST_ABORT_WR
`endif
  } seq_state_t;

  localparam logic [2:0]  PIO_ADDR_DATA = 3'd0;
  localparam logic [2:0]  PIO_ADDR_SET  = 3'd4;
  localparam logic [2:0]  PIO_ADDR_CLR  = 3'd5;
  localparam logic [31:0] PIO_BIT       = 32'h1;

endpackage

// File: rtl/qlab5_pio_seq_timer.sv
// qlab5_pio_seq_timer
//   Loadable down-counter shared by the ON and OFF phases of the sequencer.
//   Ports:
//     clk        in   system clock
//     reset      in   synchronous active-high reset (count -> 0)
//     load       in   load load_value (has priority over en)
//     load_value in   CNT_W value to load
//     en         in   decrement by one (saturates at zero)
//     zero       out  count is zero
module qlab5_pio_seq_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/qlab5_pio_seq.sv
// qlab5_pio_seq
//   Blink/pulse sequencer for the qlab5 single-bit PIO. Acts as an Avalon-MM
//   write master on the PIO slave, producing on/off pulse trains through the
//   PIO set (4) and clear (5) registers, and shares the slave with a host
//   master through a two-way arbiter (sequencer wins in its write states).
//   Optional feature: define QLAB5_PIO_SEQ_ABORT_EN to let a deasserted
//   cfg_start abort a running sequence with a final clear write.
//   Ports:
//     clk, reset                       clock, synchronous active-high reset
//     cfg_start                        level; launches a sequence from IDLE
//     cfg_on_cycles / cfg_off_cycles   high/low time (0 treated as 1)
//     cfg_repeat                       pulse count, 0 = forever
//     busy, done                       status; done is a one-cycle pulse
//     host_*                           host Avalon-MM slave side
//     pio_*                            Avalon-MM master side to the PIO
module qlab5_pio_seq
  import qlab5_pio_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 24,
  parameter int unsigned RPT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic [CNT_W-1:0] cfg_on_cycles,
  input  logic [CNT_W-1:0] cfg_off_cycles,
  input  logic [RPT_W-1:0] cfg_repeat,
  output logic             busy,
  output logic             done,
  input  logic [2:0]       host_address,
  input  logic             host_chipselect,
  input  logic             host_write_n,
  input  logic [31:0]      host_writedata,
  output logic [31:0]      host_readdata,
  output logic             host_waitrequest,
  output logic [2:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata
);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] on_q, on_d;
  logic [CNT_W-1:0] off_q, off_d;
  logic [RPT_W-1:0] rem_q, rem_d;
  logic             forever_q, forever_d;
  logic             done_q, done_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_en;
  logic             tmr_zero;
  logic             period_end;

  logic             seq_owns;
  logic [2:0]       seq_addr;

  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  qlab5_pio_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .en         (tmr_en),
    .zero       (tmr_zero)
  );

  // The write state itself is one cycle of each phase, so the count states
  // run for (period - 1) cycles: the timer is loaded with period - 2 and the
  // phase ends in the cycle it reads zero.
  always_comb begin
    state_d    = state_q;
    on_d       = on_q;
    off_d      = off_q;
    rem_d      = rem_q;
    forever_d  = forever_q;
    done_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    tmr_en     = 1'b0;
    period_end = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          on_d      = at_least_one(cfg_on_cycles);
          off_d     = at_least_one(cfg_off_cycles);
          rem_d     = cfg_repeat;
          forever_d = (cfg_repeat == '0);
          state_d   = ST_SET_WR;
        end
      end
      ST_SET_WR: begin
        tmr_load  = 1'b1;
        tmr_value = on_q - CNT_W'(2);
        state_d   = (on_q > CNT_W'(1)) ? ST_ON_CNT : ST_CLR_WR;
      end
      ST_ON_CNT: begin
        if (tmr_zero) begin
          state_d = ST_CLR_WR;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_CLR_WR: begin
        tmr_load  = 1'b1;
        tmr_value = off_q - CNT_W'(2);
        if (off_q > CNT_W'(1)) begin
          state_d = ST_OFF_CNT;
        end else begin
          period_end = 1'b1;
        end
      end
      ST_OFF_CNT: begin
        if (tmr_zero) begin
          period_end = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
`ifdef QLAB5_PIO_SEQ_ABORT_EN
      ST_ABORT_WR: begin
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (period_end) begin
      if (forever_q) begin
        state_d = ST_SET_WR;
      end else begin
        rem_d = rem_q - RPT_W'(1);
        if (rem_q == RPT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_SET_WR;
        end
      end
    end

`ifdef QLAB5_PIO_SEQ_ABORT_EN
    // Abort overrides every other transition, including a normal completion.
    if ((state_q != ST_IDLE) && (state_q != ST_ABORT_WR) && !cfg_start) begin
      state_d = ST_ABORT_WR;
      done_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      on_q      <= '0;
      off_q     <= '0;
      rem_q     <= '0;
      forever_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      on_q      <= on_d;
      off_q     <= off_d;
      rem_q     <= rem_d;
      forever_q <= forever_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

  // Arbiter: the sequencer owns the slave only in its write states; reset
  // forces pass-through so no sequencer write can leak out while in reset.
  always_comb begin
    seq_owns = 1'b0;
    seq_addr = PIO_ADDR_DATA;
    case (state_q)
      ST_SET_WR: begin
        seq_owns = 1'b1;
        seq_addr = PIO_ADDR_SET;
      end
      ST_CLR_WR: begin
        seq_owns = 1'b1;
        seq_addr = PIO_ADDR_CLR;
      end
`ifdef QLAB5_PIO_SEQ_ABORT_EN
      ST_ABORT_WR: begin
        seq_owns = 1'b1;
        seq_addr = PIO_ADDR_CLR;
      end
`endif
      default: begin
        seq_owns = 1'b0;
      end
    endcase
    if (reset) begin
      seq_owns = 1'b0;
    end

    if (seq_owns) begin
      pio_address    = seq_addr;
      pio_chipselect = 1'b1;
      pio_write_n    = 1'b0;
      pio_writedata  = PIO_BIT;
    end else begin
      pio_address    = host_address;
      pio_chipselect = host_chipselect;
      pio_write_n    = host_write_n;
      pio_writedata  = host_writedata;
    end
    host_waitrequest = seq_owns & host_chipselect;
  end

  assign host_readdata = pio_readdata;

endmodule

// File: tb/tb_qlab5_pio_seq.sv
`timescale 1ns/1ps
module tb_qlab5_pio_seq;
  import qlab5_pio_seq_pkg::*;

  localparam int CNT_W = 24;
  localparam int RPT_W = 8;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_start;
  logic [CNT_W-1:0] cfg_on_cycles;
  logic [CNT_W-1:0] cfg_off_cycles;
  logic [RPT_W-1:0] cfg_repeat;
  logic             busy;
  logic             done;
  logic [2:0]       host_address;
  logic             host_chipselect;
  logic             host_write_n;
  logic [31:0]      host_writedata;
  logic [31:0]      host_readdata;
  logic             host_waitrequest;
  logic [2:0]       pio_address;
  logic             pio_chipselect;
  logic             pio_write_n;
  logic [31:0]      pio_writedata;
  logic [31:0]      pio_readdata;

  logic pio_rst;
  logic out_port;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  done_exp[$];
  int  done_obs[$];

  qlab5_pio_seq #(
    .CNT_W (CNT_W),
    .RPT_W (RPT_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cfg_start        (cfg_start),
    .cfg_on_cycles    (cfg_on_cycles),
    .cfg_off_cycles   (cfg_off_cycles),
    .cfg_repeat       (cfg_repeat),
    .busy             (busy),
    .done             (done),
    .host_address     (host_address),
    .host_chipselect  (host_chipselect),
    .host_write_n     (host_write_n),
    .host_writedata   (host_writedata),
    .host_readdata    (host_readdata),
    .host_waitrequest (host_waitrequest),
    .pio_address      (pio_address),
    .pio_chipselect   (pio_chipselect),
    .pio_write_n      (pio_write_n),
    .pio_writedata    (pio_writedata),
    .pio_readdata     (pio_readdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-bit PIO slave model with its own reset.
  always @(posedge clk) begin
    if (pio_rst) begin
      out_port <= 1'b0;
    end else if (pio_chipselect && !pio_write_n) begin
      case (pio_address)
        PIO_ADDR_DATA: out_port <= pio_writedata[0];
        PIO_ADDR_SET:  if (pio_writedata[0]) out_port <= 1'b1;
        PIO_ADDR_CLR:  if (pio_writedata[0]) out_port <= 1'b0;
        default: ;
      endcase
    end
  end
  assign pio_readdata = {31'b0, out_port};

  // Monitor: every write reaching the PIO and every done pulse.
  always @(negedge clk) begin
    wr_t w;
    if (pio_chipselect === 1'b1 && pio_write_n === 1'b0) begin
      w.cyc  = 32'(cyc);
      w.addr = pio_address;
      w.data = pio_writedata;
      obs_q.push_back(w);
    end
    if (done === 1'b1) done_obs.push_back(cyc);
  end

  task automatic expect_wr(input int c, input logic [2:0] a);
    wr_t w;
    w.cyc  = 32'(c);
    w.addr = a;
    w.data = PIO_BIT;
    exp_q.push_back(w);
  endtask

  // Drives the configuration and returns the cycle in which SET_WR is expected.
  task automatic launch(input int on, input int off, input int rpt, output int s);
    @(posedge clk); #1;
    cfg_on_cycles  = CNT_W'(on);
    cfg_off_cycles = CNT_W'(off);
    cfg_repeat     = RPT_W'(rpt);
    cfg_start      = 1'b1;
    s = cyc + 1;
    obs_q.delete();
    done_obs.delete();
    exp_q.delete();
    done_exp.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    host_address    = 3'd2;
    host_chipselect = 1'b1;
    host_write_n    = 1'b0;
    host_writedata  = 32'hA5A5_0003;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (host_waitrequest !== 1'b0) begin miscompares++; $display("FAIL reset_wait: got %b expected 0", host_waitrequest); end
    vectors++; if (pio_address !== 3'd2) begin miscompares++; $display("FAIL reset_addr: got %0d expected 2", pio_address); end
    vectors++; if (pio_chipselect !== 1'b1 || pio_write_n !== 1'b0) begin miscompares++; $display("FAIL reset_ctl: got cs=%b wn=%b expected cs=1 wn=0", pio_chipselect, pio_write_n); end
    vectors++; if (pio_writedata !== 32'hA5A5_0003) begin miscompares++; $display("FAIL reset_wdata: got %h expected a5a50003", pio_writedata); end
    vectors++; if (host_readdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 00000000", host_readdata); end
    @(posedge clk); #1;
    reset = 1'b0; pio_rst = 1'b0;
    host_chipselect = 1'b0; host_write_n = 1'b1; host_address = 3'd0; host_writedata = '0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || pio_write_n !== 1'b1) begin miscompares++; $display("FAIL idle_after_reset: got busy=%b wn=%b expected busy=0 wn=1", busy, pio_write_n); end
  endtask

  task automatic test_pulse_train(input string name, input int on, input int off, input int rpt);
    int s, eon, eoff, p, total;
    logic exp_out, exp_busy;
    wr_t e, o;
    int de, dob;
    eon = (on == 0) ? 1 : on;
    eoff = (off == 0) ? 1 : off;
    p = eon + eoff;
    total = rpt * p;
    launch(on, off, rpt, s);
    for (int k = 0; k < rpt; k++) begin
      expect_wr(s + k * p, PIO_ADDR_SET);
      expect_wr(s + k * p + eon, PIO_ADDR_CLR);
    end
    done_exp.push_back(s + total);
    for (int rel = 0; rel <= total + 2; rel++) begin
      @(posedge clk); #1;
      if (rel == total) cfg_start = 1'b0;
      @(negedge clk);
      exp_busy = (rel < total);
      vectors++; if (busy !== exp_busy) begin miscompares++; $display("FAIL %s_busy@%0d: got %b expected %b", name, rel, busy, exp_busy); end
      if (rel > 0) begin
        exp_out = (rel <= total) && (((rel - 1) % p) < eon);
        vectors++; if (out_port !== exp_out) begin miscompares++; $display("FAIL %s_out@%0d: got %b expected %b", name, rel, out_port, exp_out); end
      end
    end
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL %s_wr_count: got %0d expected %0d", name, obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL %s_wr: got cyc=%0d addr=%0d data=%h expected cyc=%0d addr=%0d data=%h", name, o.cyc, o.addr, o.data, e.cyc, e.addr, e.data); end
    end
    vectors++; if (done_obs.size() != done_exp.size()) begin miscompares++; $display("FAIL %s_done_count: got %0d expected %0d", name, done_obs.size(), done_exp.size()); end
    while (done_exp.size() != 0 && done_obs.size() != 0) begin
      de = done_exp.pop_front(); dob = done_obs.pop_front();
      vectors++; if (dob != de) begin miscompares++; $display("FAIL %s_done_cyc: got %0d expected %0d", name, dob, de); end
    end
  endtask

  // cfg_start held high through completion: the FSM must spend exactly one
  // IDLE cycle and relaunch.
  task automatic test_back_to_back();
    int s, de, dob;
    logic exp_busy;
    wr_t e, o;
    launch(1, 2, 1, s);
    expect_wr(s, PIO_ADDR_SET);     expect_wr(s + 1, PIO_ADDR_CLR);
    expect_wr(s + 4, PIO_ADDR_SET); expect_wr(s + 5, PIO_ADDR_CLR);
    done_exp.push_back(s + 3); done_exp.push_back(s + 7);
    for (int rel = 0; rel <= 9; rel++) begin
      @(posedge clk); #1;
      if (rel == 7) cfg_start = 1'b0;
      @(negedge clk);
      exp_busy = !(rel == 3 || rel >= 7);
      vectors++; if (busy !== exp_busy) begin miscompares++; $display("FAIL b2b_busy@%0d: got %b expected %b", rel, busy, exp_busy); end
    end
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL b2b_wr_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL b2b_wr: got cyc=%0d addr=%0d expected cyc=%0d addr=%0d", o.cyc, o.addr, e.cyc, e.addr); end
    end
    vectors++; if (done_obs.size() != done_exp.size()) begin miscompares++; $display("FAIL b2b_done_count: got %0d expected %0d", done_obs.size(), done_exp.size()); end
    while (done_exp.size() != 0 && done_obs.size() != 0) begin
      de = done_exp.pop_front(); dob = done_obs.pop_front();
      vectors++; if (dob != de) begin miscompares++; $display("FAIL b2b_done_cyc: got %0d expected %0d", dob, de); end
    end
  endtask

  task automatic test_contention();
    int s, de, dob;
    logic exp_out, exp_wait, exp_busy;
    wr_t e, o;
    launch(3, 3, 1, s);
    expect_wr(s, PIO_ADDR_SET);
    expect_wr(s + 3, PIO_ADDR_CLR);
    expect_wr(s + 4, PIO_ADDR_DATA);
    done_exp.push_back(s + 6);
    for (int rel = 0; rel <= 8; rel++) begin
      @(posedge clk); #1;
      if (rel == 3) begin
        host_address = PIO_ADDR_DATA; host_chipselect = 1'b1; host_write_n = 1'b0; host_writedata = 32'h1;
      end
      if (rel == 5) begin
        host_chipselect = 1'b0; host_write_n = 1'b1;
      end
      if (rel == 6) cfg_start = 1'b0;
      @(negedge clk);
      exp_wait = (rel == 3);
      vectors++; if (host_waitrequest !== exp_wait) begin miscompares++; $display("FAIL cont_wait@%0d: got %b expected %b", rel, host_waitrequest, exp_wait); end
      exp_busy = (rel < 6);
      vectors++; if (busy !== exp_busy) begin miscompares++; $display("FAIL cont_busy@%0d: got %b expected %b", rel, busy, exp_busy); end
      if (rel > 0) begin
        exp_out = (rel != 4);
        vectors++; if (out_port !== exp_out) begin miscompares++; $display("FAIL cont_out@%0d: got %b expected %b", rel, out_port, exp_out); end
      end
      if (rel == 3) begin
        vectors++; if (pio_address !== PIO_ADDR_CLR) begin miscompares++; $display("FAIL cont_owner_addr: got %0d expected 5", pio_address); end
      end
    end
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL cont_wr_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL cont_wr: got cyc=%0d addr=%0d data=%h expected cyc=%0d addr=%0d data=%h", o.cyc, o.addr, o.data, e.cyc, e.addr, e.data); end
    end
    vectors++; if (done_obs.size() != done_exp.size()) begin miscompares++; $display("FAIL cont_done_count: got %0d expected %0d", done_obs.size(), done_exp.size()); end
    while (done_exp.size() != 0 && done_obs.size() != 0) begin
      de = done_exp.pop_front(); dob = done_obs.pop_front();
      vectors++; if (dob != de) begin miscompares++; $display("FAIL cont_done_cyc: got %0d expected %0d", dob, de); end
    end
  endtask

  // Forever run, ended by a reset that lands in a SET_WR cycle.
  task automatic test_forever();
    int s;
    logic exp_out;
    wr_t e, o;
    launch(5, 5, 0, s);
    for (int k = 0; k < 100; k++) begin
      expect_wr(s + 10 * k, PIO_ADDR_SET);
      expect_wr(s + 10 * k + 5, PIO_ADDR_CLR);
    end
    for (int rel = 0; rel < 1000; rel++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (rel > 0) begin
        exp_out = (((rel - 1) % 10) < 5);
        vectors++; if (out_port !== exp_out) begin miscompares++; $display("FAIL fwd_out@%0d: got %b expected %b", rel, out_port, exp_out); end
      end
    end
    @(posedge clk); #1;
    reset = 1'b1; cfg_start = 1'b0;
    @(negedge clk);
    vectors++; if (pio_write_n !== 1'b1 || host_waitrequest !== 1'b0) begin miscompares++; $display("FAIL fwd_reset_gate: got wn=%b wait=%b expected wn=1 wait=0", pio_write_n, host_waitrequest); end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL fwd_reset_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL fwd_wr_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL fwd_wr: got cyc=%0d addr=%0d expected cyc=%0d addr=%0d", o.cyc, o.addr, e.cyc, e.addr); end
    end
    vectors++; if (done_obs.size() != 0) begin miscompares++; $display("FAIL fwd_done_count: got %0d expected 0", done_obs.size()); end
  endtask

  task automatic test_reset_mid_run();
    int s;
    logic exp_busy;
    wr_t e, o;
    launch(10, 2, 0, s);
    expect_wr(s, PIO_ADDR_SET);
    for (int rel = 0; rel <= 12; rel++) begin
      @(posedge clk); #1;
      if (rel == 3) begin reset = 1'b1; cfg_start = 1'b0; end
      if (rel == 5) reset = 1'b0;
      @(negedge clk);
      exp_busy = (rel < 4);
      vectors++; if (busy !== exp_busy) begin miscompares++; $display("FAIL rst_busy@%0d: got %b expected %b", rel, busy, exp_busy); end
      if (rel == 4) begin
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b expected 0", done); end
      end
    end
    vectors++; if (out_port !== 1'b1) begin miscompares++; $display("FAIL rst_out: got %b expected 1", out_port); end
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rst_wr_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL rst_wr: got cyc=%0d addr=%0d expected cyc=%0d addr=%0d", o.cyc, o.addr, e.cyc, e.addr); end
    end
  endtask

`ifdef QLAB5_PIO_SEQ_ABORT_EN
  task automatic test_abort();
    int s;
    logic exp_busy, exp_out;
    wr_t e, o;
    launch(6, 2, 0, s);
    expect_wr(s, PIO_ADDR_SET);
    expect_wr(s + 3, PIO_ADDR_CLR);
    for (int rel = 0; rel <= 8; rel++) begin
      @(posedge clk); #1;
      if (rel == 2) cfg_start = 1'b0;
      @(negedge clk);
      exp_busy = (rel < 4);
      vectors++; if (busy !== exp_busy) begin miscompares++; $display("FAIL abort_busy@%0d: got %b expected %b", rel, busy, exp_busy); end
      if (rel > 0) begin
        exp_out = (rel < 4);
        vectors++; if (out_port !== exp_out) begin miscompares++; $display("FAIL abort_out@%0d: got %b expected %b", rel, out_port, exp_out); end
      end
    end
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL abort_wr_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL abort_wr: got cyc=%0d addr=%0d expected cyc=%0d addr=%0d", o.cyc, o.addr, e.cyc, e.addr); end
    end
    vectors++; if (done_obs.size() != 0) begin miscompares++; $display("FAIL abort_done_count: got %0d expected 0", done_obs.size()); end
  endtask
`endif

  initial begin
    reset           = 1'b1;
    pio_rst         = 1'b1;
    cfg_start       = 1'b0;
    cfg_on_cycles   = '0;
    cfg_off_cycles  = '0;
    cfg_repeat      = '0;
    host_address    = 3'd0;
    host_chipselect = 1'b0;
    host_write_n    = 1'b1;
    host_writedata  = '0;

    test_reset();
    test_pulse_train("single", 3, 2, 1);
    test_pulse_train("minimum", 0, 0, 4);
    test_pulse_train("train", 2, 4, 3);
    test_back_to_back();
    test_contention();
    test_forever();
    test_reset_mid_run();
`ifdef QLAB5_PIO_SEQ_ABORT_EN
    test_abort();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
